score_keeper: RTL and testbench

- Game-score stage that sits directly upstream of VGAController.
- Produces the score value VGAController shows on the 7-segment display (`counter` input) and consumes its `collided` output.
- Counts survival time in frames, freezes the score on a crash, and tracks a high score.
- Keeps a 4-digit BCD mirror so downstream display logic needs no divide/modulo.

---
 rtl/score_keeper.sv | 163 ++++++++++++++++
 tb/tb_score_keeper.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: game-score stage upstream of the VGA controller.
// Counts survival time in video frames, freezes the score on a crash,
// holds the final score for a fixed number of frames, and tracks a high
// score. A 4-digit BCD mirror of both scores is kept alongside the binary
// value so the display path needs no divide or modulo.

module score_keeper #(
    parameter int FRAMES_PER_POINT = 60,
    parameter int HOLD_FRAMES      = 120,
    parameter int MAX_SCORE        = 9999
) (
    input  logic        clk,
    input  logic        reset,       // asynchronous, active-low
    input  logic        frame_tick,
    input  logic        start,
    input  logic        collided,
    output logic [31:0] counter,
    output logic [15:0] score_bcd,
    output logic [15:0] high_bcd,
    output logic        running,
    output logic        game_over
);

    // Counter widths; a minimum of one bit keeps degenerate parameter
    // values (e.g. one frame per point) legal.
    localparam int FW = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    // 14 bits cover any score that fits in four BCD digits (max 9999).
    localparam int SW = 14;

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_POINT - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
    localparam logic [SW-1:0] SCORE_MAX  = SW'(MAX_SCORE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]    state_q,     state_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [HW-1:0] hold_cnt_q,  hold_cnt_d;
    logic          collided_q,  collided_d;
    logic [SW-1:0] score_q,     score_d;
    logic [15:0]   score_bcd_q, score_bcd_d;
    logic [SW-1:0] high_q,      high_d;
    logic [15:0]   high_bcd_q,  high_bcd_d;
    logic          crash;

    // Add one to a 4-digit BCD value; a digit at 9 wraps to 0 and carries.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A collision level counts once, on its rising edge.
    assign crash = collided & ~collided_q;

    // Next-state logic: game FSM, frame/hold counters, score and high score.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        collided_d  = collided;
        score_d     = score_q;
        score_bcd_d = score_bcd_q;
        high_d      = high_q;
        high_bcd_d  = high_bcd_q;

        case (state_q)
            ST_IDLE: begin
                // A crash arriving together with start is deliberately
                // dropped; collided_q still tracks the level.
                if (start) begin
                    state_d     = ST_RUN;
                    frame_cnt_d = '0;
                    score_d     = '0;
                    score_bcd_d = '0;
                end
            end
            ST_RUN: begin
                if (crash) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        high_bcd_d = score_bcd_q;
                    end
                end else if (frame_tick) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        // At saturation the point is dropped but the frame
                        // counter keeps wrapping.
                        if (score_q < SCORE_MAX) begin
                            score_d     = score_q + SW'(1);
                            score_bcd_d = bcd_inc(score_bcd_q);
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + FW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (frame_tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything including the high score.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            hold_cnt_q  <= '0;
            collided_q  <= 1'b0;
            score_q     <= '0;
            score_bcd_q <= '0;
            high_q      <= '0;
            high_bcd_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            collided_q  <= collided_d;
            score_q     <= score_d;
            score_bcd_q <= score_bcd_d;
            high_q      <= high_d;
            high_bcd_q  <= high_bcd_d;
        end
    end

    assign counter   = {{(32-SW){1'b0}}, score_q};
    assign score_bcd = score_bcd_q;
    assign high_bcd  = high_bcd_q;
    assign running   = (state_q == ST_RUN);
    assign game_over = (state_q == ST_HOLD);

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper. Two instances: one with default
// parameters for the real-timing scenarios, one with a fast frame rate so
// saturation and randomized play fit in a short run.

module tb_score_keeper;

    localparam int M_FPP  = 60;
    localparam int M_HOLD = 120;
    localparam int F_FPP  = 2;
    localparam int F_HOLD = 3;
    localparam int MAXS   = 9999;

    logic clk = 1'b0;
    logic reset;

    logic        m_tick, m_start, m_coll;
    logic [31:0] m_counter;
    logic [15:0] m_score_bcd, m_high_bcd;
    logic        m_running, m_game_over;

    logic        f_tick, f_start, f_coll;
    logic [31:0] f_counter;
    logic [15:0] f_score_bcd, f_high_bcd;
    logic        f_running, f_game_over;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    score_keeper dut_main (
        .clk(clk), .reset(reset),
        .frame_tick(m_tick), .start(m_start), .collided(m_coll),
        .counter(m_counter), .score_bcd(m_score_bcd), .high_bcd(m_high_bcd),
        .running(m_running), .game_over(m_game_over)
    );

    score_keeper #(.FRAMES_PER_POINT(F_FPP), .HOLD_FRAMES(F_HOLD), .MAX_SCORE(MAXS)) dut_fast (
        .clk(clk), .reset(reset),
        .frame_tick(f_tick), .start(f_start), .collided(f_coll),
        .counter(f_counter), .score_bcd(f_score_bcd), .high_bcd(f_high_bcd),
        .running(f_running), .game_over(f_game_over)
    );

    // ---------------- behavioural reference model ----------------
    localparam int P_IDLE = 0, P_PLAY = 1, P_OVER = 2;

    typedef struct {
        int phase;
        int score;
        int frames;
        int hold;
        int high;
        bit prev_coll;
    } mdl_t;

    mdl_t mm, fm;

    function automatic mdl_t model_step(mdl_t m, bit tick, bit st, bit coll, int fpp, int hf);
        mdl_t n;
        bit   hit;
        n   = m;
        hit = coll && !m.prev_coll;
        n.prev_coll = coll;
        if (m.phase == P_IDLE) begin
            if (st) begin
                n.phase  = P_PLAY;
                n.score  = 0;
                n.frames = 0;
            end
        end else if (m.phase == P_PLAY) begin
            if (hit) begin
                n.phase = P_OVER;
                n.hold  = 0;
                if (m.score > m.high) n.high = m.score;
            end else if (tick) begin
                n.frames = (m.frames + 1) % fpp;
                if (n.frames == 0 && m.score < MAXS) n.score = m.score + 1;
            end
        end else begin
            if (tick) begin
                n.hold = m.hold + 1;
                if (n.hold == hf) n.phase = P_IDLE;
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic mdl_t model_reset();
        mdl_t m;
        m = '{default: 0};
        return m;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs to both instances, advance the models,
    // and return 1 time unit after the edge.
    task automatic step(input bit mt, input bit ms, input bit mc,
                        input bit ft, input bit fs, input bit fc);
        m_tick = mt; m_start = ms; m_coll = mc;
        f_tick = ft; f_start = fs; f_coll = fc;
        @(posedge clk);
        mm = model_step(mm, mt, ms, mc, M_FPP, M_HOLD);
        fm = model_step(fm, ft, fs, fc, F_FPP, F_HOLD);
        #1;
    endtask

    task automatic step_main(input bit t, input bit s, input bit c);
        step(t, s, c, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step_fast(input bit t, input bit s, input bit c);
        step(1'b0, 1'b0, 1'b0, t, s, c);
    endtask

    task automatic ticks_main(input int n);
        for (int i = 0; i < n; i++) step_main(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        m_tick = 0; m_start = 0; m_coll = 0;
        f_tick = 0; f_start = 0; f_coll = 0;
        reset = 1'b0;
        mm = model_reset();
        fm = model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic check_main_model(input string tag);
        check({tag, " m_counter"}, m_counter, 32'(mm.score));
        check({tag, " m_score_bcd"}, 32'(m_score_bcd), 32'(to_bcd(mm.score)));
        check({tag, " m_high_bcd"}, 32'(m_high_bcd), 32'(to_bcd(mm.high)));
        check({tag, " m_running"}, 32'(m_running), 32'(mm.phase == P_PLAY));
        check({tag, " m_game_over"}, 32'(m_game_over), 32'(mm.phase == P_OVER));
    endtask

    task automatic check_fast_model(input string tag);
        check({tag, " f_counter"}, f_counter, 32'(fm.score));
        check({tag, " f_score_bcd"}, 32'(f_score_bcd), 32'(to_bcd(fm.score)));
        check({tag, " f_high_bcd"}, 32'(f_high_bcd), 32'(to_bcd(fm.high)));
        check({tag, " f_running"}, 32'(f_running), 32'(fm.phase == P_PLAY));
        check({tag, " f_game_over"}, 32'(f_game_over), 32'(fm.phase == P_OVER));
    endtask

    // ---------------- directed vector table (fast instance) ----------------
    typedef struct {
        bit          tick;
        bit          start;
        bit          coll;
        int          cnt;
        logic [15:0] bcd;
        logic [15:0] high;
        bit          run;
        bit          go;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // FRAMES_PER_POINT=2, HOLD_FRAMES=3
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 0, 16'h0000, 16'h0000, 1'b1, 1'b0}; // start
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 0, 16'h0000, 16'h0000, 1'b1, 1'b0}; // frame 1
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1, 16'h0001, 16'h0000, 1'b1, 1'b0}; // point
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1, 16'h0001, 16'h0001, 1'b0, 1'b1}; // crash+tick
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1, 16'h0001, 16'h0001, 1'b0, 1'b1}; // held, hold 1
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1, 16'h0001, 16'h0001, 1'b0, 1'b1}; // hold 2
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1, 16'h0001, 16'h0001, 1'b0, 1'b0}; // back to idle
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 0, 16'h0000, 16'h0001, 1'b1, 1'b0}; // start+crash
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0001, 1'b1, 1'b0}; // held level
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 0, 16'h0000, 16'h0001, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1, 16'h0001, 16'h0001, 1'b1, 1'b0};

        do_reset();

        // --- reset state, idle for 1000 cycles ---
        repeat (1000) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle counter", m_counter, 32'd0);
        check("idle score_bcd", 32'(m_score_bcd), 32'h0000);
        check("idle high_bcd", 32'(m_high_bcd), 32'h0000);
        check("idle running", 32'(m_running), 32'd0);
        check("idle game_over", 32'(m_game_over), 32'd0);

        // --- table-driven sequence on fast instance ---
        for (int i = 0; i < 11; i++) begin
            step_fast(vecs[i].tick, vecs[i].start, vecs[i].coll);
            check($sformatf("vec%0d counter", i), f_counter, 32'(vecs[i].cnt));
            check($sformatf("vec%0d score_bcd", i), 32'(f_score_bcd), 32'(vecs[i].bcd));
            check($sformatf("vec%0d high_bcd", i), 32'(f_high_bcd), 32'(vecs[i].high));
            check($sformatf("vec%0d running", i), 32'(f_running), 32'(vecs[i].run));
            check($sformatf("vec%0d game_over", i), 32'(f_game_over), 32'(vecs[i].go));
        end

        // --- saturation on fast instance, BCD ripple checked every cycle ---
        for (int i = 0; i < 25000 && fm.score < MAXS; i++) begin
            step_fast(1'b1, 1'b0, 1'b0);
            check("sat counter", f_counter, 32'(fm.score));
            check("sat score_bcd", 32'(f_score_bcd), 32'(to_bcd(fm.score)));
        end
        check("sat reached counter", f_counter, 32'd9999);
        check("sat reached bcd", 32'(f_score_bcd), 32'h9999);
        repeat (60) step_fast(1'b1, 1'b0, 1'b0);
        check("sat hold counter", f_counter, 32'd9999);
        check("sat hold bcd", 32'(f_score_bcd), 32'h9999);
        check("sat running", 32'(f_running), 32'd1);

        // --- main instance: 600 ticks -> score 10 ---
        step_main(1'b0, 1'b1, 1'b0);
        check("run after start", 32'(m_running), 32'd1);
        ticks_main(59);
        check("59 ticks counter", m_counter, 32'd0);
        ticks_main(1);
        check("60 ticks counter", m_counter, 32'd1);
        ticks_main(480);
        check("540 ticks bcd", 32'(m_score_bcd), 32'h0009);
        ticks_main(60);
        check("600 ticks counter", m_counter, 32'd10);
        check("600 ticks bcd", 32'(m_score_bcd), 32'h0010);
        check("600 ticks running", 32'(m_running), 32'd1);

        do_reset();

        // --- score 7, collided held 50 cycles ---
        step_main(1'b0, 1'b1, 1'b0);
        ticks_main(420);
        check("g1 counter", m_counter, 32'd7);
        repeat (50) step_main(1'b0, 1'b0, 1'b1);
        check("g1 game_over", 32'(m_game_over), 32'd1);
        check("g1 running", 32'(m_running), 32'd0);
        check("g1 high_bcd", 32'(m_high_bcd), 32'h0007);
        step_main(1'b0, 1'b0, 1'b0);
        ticks_main(119);
        check("g1 hold 119", 32'(m_game_over), 32'd1);
        ticks_main(1);
        check("g1 idle game_over", 32'(m_game_over), 32'd0);
        check("g1 idle running", 32'(m_running), 32'd0);
        check("g1 idle score_bcd", 32'(m_score_bcd), 32'h0007);

        // --- second game: score 5, high stays 7 ---
        step_main(1'b0, 1'b1, 1'b0);
        check("g2 cleared", m_counter, 32'd0);
        ticks_main(300);
        step_main(1'b0, 1'b0, 1'b1);
        check("g2 game_over", 32'(m_game_over), 32'd1);
        check("g2 high_bcd", 32'(m_high_bcd), 32'h0007);
        step_main(1'b0, 1'b0, 1'b0);
        ticks_main(120);

        // --- third game: score 7 equals high ---
        step_main(1'b0, 1'b1, 1'b0);
        ticks_main(420);
        step_main(1'b0, 1'b0, 1'b1);
        check("g3 high_bcd", 32'(m_high_bcd), 32'h0007);
        check("g3 score_bcd", 32'(m_score_bcd), 32'h0007);
        step_main(1'b0, 1'b0, 1'b0);
        ticks_main(120);
        check_main_model("g3 end");

        // --- crash coincident with qualifying tick ---
        step_main(1'b0, 1'b1, 1'b0);
        ticks_main(59);
        step_main(1'b1, 1'b0, 1'b1);
        check("coinc counter", m_counter, 32'd0);
        check("coinc game_over", 32'(m_game_over), 32'd1);
        step_main(1'b0, 1'b0, 1'b0);
        ticks_main(120);

        // --- asynchronous reset mid-RUN ---
        step_main(1'b0, 1'b1, 1'b0);
        ticks_main(100);
        check("pre-reset counter", m_counter, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async counter", m_counter, 32'd0);
        check("async score_bcd", 32'(m_score_bcd), 32'h0000);
        check("async high_bcd", 32'(m_high_bcd), 32'h0000);
        check("async running", 32'(m_running), 32'd0);
        check("async game_over", 32'(m_game_over), 32'd0);

        // --- randomized play on both instances against the model ---
        do_reset();
        begin
            bit lvl;
            lvl = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                bit t, s;
                t = ($urandom_range(0, 1) == 1);
                s = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 5) == 0) lvl = ~lvl;
                step(1'b1, s, lvl, t, s, lvl);
                check_main_model("rand");
                check_fast_model("rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
